// File: rtl/led_pattern_driver_pkg.sv
// Shared definitions for the dock LED pattern driver: LED count, mode codes,
// config FSM states and the duty-compare helper.
package led_pattern_driver_pkg;

    localparam int LED_COUNT = 4;

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_PWM     = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;

    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    // Level 255 yields 255/256 duty; only MODE_ON reaches 100 %.
    function automatic logic duty_on(input logic [7:0] pwm_cnt, input logic [7:0] level);
        return (pwm_cnt < level);
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: clock prescaler, 8-bit PWM counter, period-boundary
// strobe and the blink half-phase toggle.
module led_pwm_timebase #(
    parameter int PWM_DIV     = 27,
    parameter int BLINK_WRAPS = 1953
) (
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [7:0] pwm_cnt,
    output logic       pwm_wrap,
    output logic       blink_phase
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int BLK_W = (BLINK_WRAPS > 1) ? $clog2(BLINK_WRAPS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_WRAPS - 1);

    logic [PRE_W-1:0] prescale_r;
    logic [7:0]       pwm_cnt_r;
    logic [BLK_W-1:0] blink_cnt_r;
    logic             blink_phase_r;
    logic             tick_s;
    logic             wrap_s;

    assign tick_s      = (prescale_r == PRE_MAX);
    assign wrap_s      = tick_s && (pwm_cnt_r == 8'hFF);
    assign tick        = tick_s;
    assign pwm_cnt     = pwm_cnt_r;
    assign pwm_wrap    = wrap_s;
    assign blink_phase = blink_phase_r;

    // Prescaler, PWM counter and blink phase counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_r    <= '0;
            pwm_cnt_r     <= 8'd0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            if (tick_s) begin
                prescale_r <= '0;
                pwm_cnt_r  <= pwm_cnt_r + 8'd1;
            end else begin
                prescale_r <= prescale_r + PRE_W'(1);
            end
            if (wrap_s) begin
                if (blink_cnt_r == BLK_MAX) begin
                    blink_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BLK_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// Dock LED driver: per-LED mode/level registers updated through a valid/ready
// port and committed only at PWM period boundaries. Optional BREATHE mode is
// built when LED_PATTERN_BREATHE_EN is defined.
module led_pattern_driver
    import led_pattern_driver_pkg::*;
#(
    parameter int PWM_DIV     = 27,
    parameter int BLINK_WRAPS = 1953,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_index,
    input  logic [2:0] cfg_mode,
    input  logic [7:0] cfg_level,
    output logic [3:0] led_out,
    output logic       pwm_wrap
);

    localparam logic [LED_COUNT-1:0] UNLIT = {LED_COUNT{ACTIVE_LOW}};

    logic                 tick_s;
    logic [7:0]           pwm_cnt_s;
    logic                 pwm_wrap_s;
    logic                 blink_phase_s;
    logic                 commit_s;
    logic [7:0]           breathe_lvl_s;
    logic [LED_COUNT-1:0] lit_s;

    cfg_state_t           state_r;
    logic                 cfg_ready_r;
    logic [1:0]           pend_idx_r;
    logic [2:0]           pend_mode_r;
    logic [7:0]           pend_level_r;
    logic [2:0]           mode_r  [LED_COUNT];
    logic [7:0]           level_r [LED_COUNT];
    logic [LED_COUNT-1:0] led_out_r;

    led_pwm_timebase #(
        .PWM_DIV     (PWM_DIV),
        .BLINK_WRAPS (BLINK_WRAPS)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick_s),
        .pwm_cnt     (pwm_cnt_s),
        .pwm_wrap    (pwm_wrap_s),
        .blink_phase (blink_phase_s)
    );

    // pwm_wrap already implies tick; the AND keeps the strobe explicitly tick-qualified.
    assign commit_s  = tick_s && pwm_wrap_s;
    assign cfg_ready = cfg_ready_r;
    assign led_out   = led_out_r;
    assign pwm_wrap  = pwm_wrap_s;

`ifdef LED_PATTERN_BREATHE_EN
    logic [7:0] breathe_lvl_r;
    logic       breathe_up_r;

    assign breathe_lvl_s = breathe_lvl_r;

    // Shared triangle level: one step per PWM period, turning at 255 and 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            breathe_lvl_r <= 8'd0;
            breathe_up_r  <= 1'b1;
        end else if (pwm_wrap_s) begin
            if (breathe_up_r) begin
                if (breathe_lvl_r == 8'hFF) begin
                    breathe_up_r  <= 1'b0;
                    breathe_lvl_r <= 8'hFE;
                end else begin
                    breathe_lvl_r <= breathe_lvl_r + 8'd1;
                end
            end else begin
                if (breathe_lvl_r == 8'h00) begin
                    breathe_up_r  <= 1'b1;
                    breathe_lvl_r <= 8'h01;
                end else begin
                    breathe_lvl_r <= breathe_lvl_r - 8'd1;
                end
            end
        end else begin
            breathe_lvl_r <= breathe_lvl_r;
            breathe_up_r  <= breathe_up_r;
        end
    end
`else
    assign breathe_lvl_s = 8'd0;
`endif

    // Config FSM: capture one request, commit it on the next period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= CFG_IDLE;
            cfg_ready_r  <= 1'b1;
            pend_idx_r   <= 2'd0;
            pend_mode_r  <= MODE_OFF;
            pend_level_r <= 8'd0;
            for (int i = 0; i < LED_COUNT; i++) begin
                mode_r[i]  <= MODE_OFF;
                level_r[i] <= 8'd0;
            end
        end else begin
            case (state_r)
                CFG_IDLE: begin
                    if (cfg_valid && cfg_ready_r) begin
                        pend_idx_r   <= cfg_index;
                        pend_mode_r  <= cfg_mode;
                        pend_level_r <= cfg_level;
                        cfg_ready_r  <= 1'b0;
                        state_r      <= CFG_PEND;
                    end else begin
                        cfg_ready_r  <= 1'b1;
                    end
                end
                CFG_PEND: begin
                    if (commit_s) begin
                        mode_r[pend_idx_r]  <= pend_mode_r;
                        level_r[pend_idx_r] <= pend_level_r;
                        cfg_ready_r         <= 1'b1;
                        state_r             <= CFG_IDLE;
                    end else begin
                        cfg_ready_r         <= 1'b0;
                    end
                end
                default: begin
                    cfg_ready_r <= 1'b1;
                    state_r     <= CFG_IDLE;
                end
            endcase
        end
    end

    // Per-LED lit term from mode, level and the shared timebase.
    always_comb begin
        lit_s = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            case (mode_r[i])
                MODE_ON:    lit_s[i] = 1'b1;
                MODE_BLINK: lit_s[i] = blink_phase_s &&
                                       ((level_r[i] == 8'd0) || duty_on(pwm_cnt_s, level_r[i]));
                MODE_PWM:   lit_s[i] = duty_on(pwm_cnt_s, level_r[i]);
`ifdef LED_PATTERN_BREATHE_EN
                MODE_BREATHE: lit_s[i] = duty_on(pwm_cnt_s, breathe_lvl_s);
`endif
                default:    lit_s[i] = 1'b0;
            endcase
        end
    end

    // Registered pin drive with polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out_r <= UNLIT;
        end else begin
            led_out_r <= lit_s ^ UNLIT;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Self-checking bench for led_pattern_driver: cycle model derived from elapsed
// cycles since reset, directed scenarios plus randomized config traffic.
module tb_led_pattern_driver;

    localparam int PWM_DIV     = 1;
    localparam int BLINK_WRAPS = 2;
    localparam int PERIOD      = 256 * PWM_DIV;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_index;
    logic [2:0] cfg_mode;
    logic [7:0] cfg_level;
    logic [3:0] led_out;
    logic       pwm_wrap;

    int checks;
    int errors;

    // reference state
    int         n;
    logic [2:0] m_mode  [4];
    logic [7:0] m_level [4];
    bit         m_pend;
    logic [1:0] p_idx;
    logic [2:0] p_mode;
    logic [7:0] p_level;
    bit         m_ready;
    logic [3:0] m_led;

    led_pattern_driver #(
        .PWM_DIV     (PWM_DIV),
        .BLINK_WRAPS (BLINK_WRAPS),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_index (cfg_index),
        .cfg_mode  (cfg_mode),
        .cfg_level (cfg_level),
        .led_out   (led_out),
        .pwm_wrap  (pwm_wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int cnt_at(int k);
        return (k / PWM_DIV) % 256;
    endfunction

    function automatic bit wrap_at(int k);
        return (k % PERIOD) == (PERIOD - 1);
    endfunction

    function automatic bit phase_at(int k);
        return ((k / PERIOD) / BLINK_WRAPS) % 2 == 1;
    endfunction

    function automatic int breathe_at(int k);
        int r;
        r = (k / PERIOD) % 510;
        return (r <= 255) ? r : 510 - r;
    endfunction

    function automatic bit lit_of(logic [2:0] mode, logic [7:0] level, int k);
        int c;
        c = cnt_at(k);
        case (mode)
            3'd1: return 1'b1;
            3'd2: return phase_at(k) && (level == 8'd0 || c < int'(level));
            3'd3: return c < int'(level);
`ifdef LED_PATTERN_BREATHE_EN
            3'd4: return c < breathe_at(k);
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, n, act, exp);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            m_mode[i]  = 3'd0;
            m_level[i] = 8'd0;
        end
        m_pend  = 1'b0;
        m_ready = 1'b1;
        m_led   = 4'hF;
    endtask

    // Advance one clock: update the model from pre-edge state, then compare.
    task automatic step();
        logic [3:0] nl;
        @(posedge clk);
        for (int i = 0; i < 4; i++) nl[i] = ~lit_of(m_mode[i], m_level[i], n);
        if (m_pend && wrap_at(n)) begin
            m_mode[p_idx]  = p_mode;
            m_level[p_idx] = p_level;
            m_pend  = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready && cfg_valid) begin
            p_idx   = cfg_index;
            p_mode  = cfg_mode;
            p_level = cfg_level;
            m_pend  = 1'b1;
            m_ready = 1'b0;
        end
        m_led = nl;
        n++;
        #1;
        chk("led_out",   32'(led_out),   32'(m_led));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
        chk("pwm_wrap",  32'(pwm_wrap),  32'(wrap_at(n)));
    endtask

    task automatic request(logic [1:0] idx, logic [2:0] mode, logic [7:0] lvl);
        bit acc;
        int b;
        cfg_valid = 1'b1;
        cfg_index = idx;
        cfg_mode  = mode;
        cfg_level = lvl;
        acc = 1'b0;
        b = 0;
        while (!acc && b < 3000) begin
            acc = m_ready;
            step();
            b++;
        end
        cfg_valid = 1'b0;
        if (!acc) chk("request_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_commit();
        int b;
        b = 0;
        while (!m_ready && b < 3000) begin
            step();
            b++;
        end
        if (!m_ready) chk("commit_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_index = 2'd0;
        cfg_mode  = 3'd0;
        cfg_level = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_led",   32'(led_out),   32'hF);
        chk("reset_ready", 32'(cfg_ready), 32'h1);
        chk("reset_wrap",  32'(pwm_wrap),  32'h0);
        rst = 1'b0;
        model_reset();

        // idle after reset: nothing lit
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (led_out != 4'hF) cnt++;
        end
        chk("idle_lit_cycles", 32'(cnt), 32'd0);

        // ON commit on LED0
        repeat (10) step();
        request(2'd0, 3'd1, 8'd0);
        chk("on_pending_ready", 32'(cfg_ready), 32'd0);
        wait_commit();
        step();
        chk("on_led0", 32'(led_out[0]), 32'd0);

        // PWM level 64 on LED1: 64 low cycles per period starting at pwm_cnt 0
        request(2'd1, 3'd3, 8'd64);
        wait_commit();
        step();
        chk("pwm_first_low", 32'(led_out[1]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (led_out[1] == 1'b0) cnt++;
            step();
        end
        chk("pwm_low_cycles", 32'(cnt), 32'd64);

        // BLINK level 0 on LED2: half lit over four periods
        request(2'd2, 3'd2, 8'd0);
        wait_commit();
        step();
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            if (led_out[2] == 1'b0) cnt++;
            step();
        end
        chk("blink_lit_cycles", 32'(cnt), 32'd512);

        // Backpressure: three held requests, stray pulses while pending
        request(2'd3, 3'd1, 8'd0);
        request(2'd0, 3'd3, 8'd128);
        request(2'd1, 3'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_index = 2'd2;
            cfg_mode  = 3'd0;
            step();
            cfg_valid = 1'b0;
            step();
        end
        wait_commit();
        step();
        chk("bp_led3_on",  32'(led_out[3]), 32'd0);
        chk("bp_led1_off", 32'(led_out[1]), 32'd1);
        chk("bp_led2_mode_kept", 32'(dut.mode_r[2]), 32'd2);

        // Reserved mode 6 and mode 4
        request(2'd3, 3'd6, 8'd200);
        request(2'd1, 3'd4, 8'd90);
        wait_commit();
        step();
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            if (led_out[3] == 1'b0) cnt++;
            step();
        end
        chk("reserved_lit_cycles", 32'(cnt), 32'd0);

        // Randomized traffic, including pulses while not ready
        for (int i = 0; i < 6000; i++) begin
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_index = 2'($urandom_range(0, 3));
            cfg_mode  = 3'($urandom_range(0, 7));
            cfg_level = 8'($urandom_range(0, 255));
            step();
        end
        cfg_valid = 1'b0;

        // Reset mid-PEND
        request(2'd0, 3'd1, 8'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_led",   32'(led_out),   32'hF);
        chk("midreset_ready", 32'(cfg_ready), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            step();
            if (led_out != 4'hF) cnt++;
        end
        chk("post_reset_lit_cycles", 32'(cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
